inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/inst_fetch.sv | 126 ++++++++++++
 tb/tb_inst_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The compressed (RVC) datapath is enabled by defining FETCH_RVC_EN.
package fetch_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_1000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        compressed;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FETCH      = 2'd1,
    STALL      = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Decode queue: power-of-two circular buffer with synchronous flush.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: drives pc/request to instcache and queues returned
// instructions for decode. Define FETCH_RVC_EN for 16-bit compressed support.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [63:0]             pc,
  output logic                    request,
  input  logic                    inst_valid,
  input  logic                    inst_compressed,
  input  logic [31:0]             inst,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_pc,
  output logic [31:0]             out_inst,
  output logic                    out_compressed,
  output fetch_state_t            state,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

  // Handshakes: the instcache response is taken only while request=1, and a
  // decode transfer happens on out_valid && out_ready. redirect_valid voids both.
  fetch_entry_t  push_data;
  fetch_entry_t  head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [63:0]   pc_step;
  logic [63:0]   redirect_target;
  logic          entry_compressed;

`ifdef FETCH_RVC_EN
  assign entry_compressed = inst_compressed;
  assign pc_step          = inst_compressed ? 64'd2 : 64'd4;
  assign redirect_target  = {redirect_pc[63:1], 1'b0};
  assign out_compressed   = out_valid && head.compressed;
  logic unused_bits;
  assign unused_bits = redirect_pc[0];
`else
  assign entry_compressed = 1'b0;
  assign pc_step          = 64'd4;
  assign redirect_target  = {redirect_pc[63:2], 2'b00};
  assign out_compressed   = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{inst_compressed, redirect_pc[1:0], head.compressed};
`endif

  assign pop        = out_valid && out_ready && !redirect_valid;
  assign accept     = request && inst_valid && !redirect_valid && (!full || pop);
  assign count_next = count + CW'(accept) - CW'(pop);

  assign push_data.pc         = pc;
  assign push_data.inst       = inst;
  assign push_data.compressed = entry_compressed;

  fetch_fifo #(
    .DEPTH   (QDEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .count     (count)
  );

  // Head fields are zeroed while empty so a flushed entry never leaks out.
  assign out_valid = !empty;
  assign out_pc    = out_valid ? head.pc : 64'd0;
  assign out_inst  = out_valid ? head.inst : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_HOLD;
      pc      <= RESET_PC;
      request <= 1'b0;
    end else if (redirect_valid) begin
      state   <= FETCH;
      pc      <= redirect_target;
      request <= 1'b1;
    end else begin
      case (state)
        RESET_HOLD: begin
          state   <= FETCH;
          request <= 1'b1;
        end
        FETCH: begin
          if (accept) begin
            pc <= pc + pc_step;
            if (count_next == FULL_COUNT) begin
              state   <= STALL;
              request <= 1'b0;
            end
          end
        end
        STALL: begin
          if (count_next < FULL_COUNT) begin
            state   <= FETCH;
            request <= 1'b1;
          end
        end
        default: begin
          state   <= RESET_HOLD;
          request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic checked
// against a queue-based reference model of the fetch unit.
module tb_inst_fetch;
  import fetch_pkg::*;

  localparam int          QD  = 4;
  localparam logic [63:0] RPC = 64'h1000;
`ifdef FETCH_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [63:0]  pc;
  logic         request;
  logic         inst_valid;
  logic         inst_compressed;
  logic [31:0]  inst;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_pc;
  logic [31:0]  out_inst;
  logic         out_compressed;
  fetch_state_t state;
  logic [2:0]   count;

  inst_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .request         (request),
    .inst_valid      (inst_valid),
    .inst_compressed (inst_compressed),
    .inst            (inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_compressed  (out_compressed),
    .state           (state),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected decode queue, expected pc and request.
  fetch_entry_t exp_q[$];
  logic [63:0]  m_pc;
  bit           m_req;
  bit           m_hold;
  int           n_tests;
  int           n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("pc", pc, m_pc);
    check_eq("request", 64'(request), 64'(m_req));
    check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check_eq("count", 64'(count), 64'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check_eq("out_pc", out_pc, exp_q[0].pc);
      check_eq("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
      check_eq("out_compressed", 64'(out_compressed), 64'(exp_q[0].compressed));
    end
  endtask

  // Drive one cycle of inputs (caller is at a falling edge), advance the
  // model by the rules of the fetch unit, then check at the next falling edge.
  task automatic cycle(input bit iv, input bit ic, input logic [31:0] ins,
                       input bit rv, input logic [63:0] rpc, input bit ordy);
    fetch_entry_t e;
    inst_valid      = iv;
    inst_compressed = ic;
    inst            = ins;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    out_ready       = ordy;
    if (rv) begin
      exp_q.delete();
      m_pc   = RVC ? (rpc & ~64'd1) : (rpc & ~64'd3);
      m_req  = 1'b1;
      m_hold = 1'b0;
    end else if (m_hold) begin
      m_hold = 1'b0;
      m_req  = 1'b1;
    end else begin
      if (exp_q.size() != 0 && ordy) exp_q.delete(0);
      if (m_req && iv) begin
        e.pc         = m_pc;
        e.inst       = ins;
        e.compressed = RVC ? ic : 1'b0;
        exp_q.push_back(e);
        m_pc = m_pc + ((RVC && ic) ? 64'd2 : 64'd4);
      end
      m_req = (exp_q.size() < QD);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc   = RPC;
    m_req  = 1'b0;
    m_hold = 1'b1;
  endtask

  task automatic do_reset();
    inst_valid = 0; inst_compressed = 0; inst = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_pc", pc, RPC);
    check_eq("rst_request", 64'(request), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_inst", 64'(out_inst), 64'd0);
    check_eq("rst_out_compressed", 64'(out_compressed), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    #1;
    do_reset();

    // Straight-line 4-byte fetch with decode always ready.
    cycle(1, 0, 32'h1111_0001, 0, '0, 1);
    check_eq("first_req", 64'(request), 64'd1);
    check_eq("first_pc", pc, 64'h1000);
    cycle(1, 0, 32'h1111_0002, 0, '0, 1);
    check_eq("seq_pc_1004", pc, 64'h1004);
    check_eq("seq_out_pc", out_pc, 64'h1000);
    cycle(1, 0, 32'h1111_0003, 0, '0, 1);
    check_eq("seq_pc_1008", pc, 64'h1008);
    check_eq("seq_out_pc2", out_pc, 64'h1004);

    // Alternating compressed / full-size returns from 0x1000.
    cycle(0, 0, '0, 1, 64'h1000, 1);
    cycle(1, 1, 32'h0000_4501, 0, '0, 1);
    check_eq("rvc_pc1", pc, RVC ? 64'h1002 : 64'h1004);
    cycle(1, 0, 32'h2222_0001, 0, '0, 1);
    check_eq("rvc_pc2", pc, RVC ? 64'h1006 : 64'h1008);
    cycle(1, 1, 32'h0000_4502, 0, '0, 1);
    check_eq("rvc_pc3", pc, RVC ? 64'h1008 : 64'h100c);

    // Fill the queue with decode stalled, then release one entry.
    do_reset();
    cycle(0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 32'h3333_0000 + 32'(i), 0, '0, 0);
    check_eq("full_count", 64'(count), 64'd4);
    check_eq("full_request", 64'(request), 64'd0);
    cycle(1, 0, 32'h3333_00ff, 0, '0, 1);
    check_eq("release_request", 64'(request), 64'd1);
    cycle(1, 0, 32'h3333_0100, 0, '0, 0);
    check_eq("refill_count", 64'(count), 64'd4);

    // Redirect with three queued entries and a same-cycle response.
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 0, '0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 32'h4444_0000 + 32'(i), 0, '0, 0);
    check_eq("pre_redirect_count", 64'(count), 64'd3);
    cycle(1, 0, 32'hDEAD_BEEF, 1, 64'h2003, 1);
    check_eq("redirect_out_valid", 64'(out_valid), 64'd0);
    check_eq("redirect_pc", pc, RVC ? 64'h2002 : 64'h2000);
    for (int i = 0; i < 6; i++) cycle(1, 0, 32'h5555_0000 + 32'(i), 0, '0, 1);

    // 64-bit pc wrap.
    cycle(0, 0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    cycle(1, 0, 32'h6666_0001, 0, '0, 1);
    check_eq("wrap_pc", pc, 64'd0);

    // Long miss, then reset pulsed asynchronously in the middle of it.
    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 0, '0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pc", pc, RPC);
    check_eq("async_rst_request", 64'(request), 64'd0);
    check_eq("async_rst_count", 64'(count), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'h7777_0000 + 32'(i), 0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 31) == 0, {$urandom, $urandom},
            $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
